// File: rtl/toll_pkg.sv
// toll_pkg: shared types and constants for the toll-lane controller family.
// Holds the coin values, the cents type and the lane state enum.
package toll_pkg;

    localparam int unsigned NICKEL_C   = 5;
    localparam int unsigned DIME_C     = 10;
    localparam int unsigned QUARTER_C  = 25;

    localparam int unsigned COIN_SUM_W = 6;

    typedef logic [7:0]            cents_t;
    typedef logic [COIN_SUM_W-1:0] coin_sum_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OPEN,
        VIOLATE
    } toll_state_t;

endpackage

// File: rtl/toll_coin_sum.sv
// toll_coin_sum: combinational value of the coins accepted in one cycle.
// Every coin line asserted in the same cycle is counted, giving 0..40 cents.
module toll_coin_sum
    import toll_pkg::*;
(
    input  logic      N,
    input  logic      D,
    input  logic      Q,
    output coin_sum_t coin_sum
);

    assign coin_sum = (N ? coin_sum_t'(NICKEL_C)  : '0)
                    + (D ? coin_sum_t'(DIME_C)    : '0)
                    + (Q ? coin_sum_t'(QUARTER_C) : '0);

endmodule

// File: rtl/toll_controller.sv
// toll_controller: one-lane toll booth sequencer.
// Detects a car, accumulates coin credit, opens the gate once the toll is
// covered and raises a timed alarm when a car leaves without paying.
// Optional change output is enabled by defining TOLL_CHANGE_EN.
module toll_controller
    import toll_pkg::*;
#(
    parameter int unsigned TOLL_CENTS   = 35,
    parameter int unsigned ALARM_CYCLES = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   car_arrive,
    input  logic   car_exit,
    input  logic   N,
    input  logic   D,
    input  logic   Q,
    output logic   Paid,
    output logic   Stop,
    output cents_t credit,
    output logic   alarm
`ifdef TOLL_CHANGE_EN
    ,
    output cents_t change,
    output logic   change_valid
`endif
);

    localparam int unsigned ALARM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam cents_t TOLL_C = cents_t'(TOLL_CENTS);
    localparam logic [ALARM_W-1:0] ALARM_LOAD = ALARM_W'(ALARM_CYCLES - 1);

    toll_state_t        state_q, state_d;
    cents_t             credit_q, credit_d;
    logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;

    coin_sum_t coin_sum;
    cents_t    credit_sum;
    logic      go_open;
    logic      go_violate;
    logic      alarm_done;

    toll_coin_sum u_coin_sum (
        .N        (N),
        .D        (D),
        .Q        (Q),
        .coin_sum (coin_sum)
    );

    // Credit never overflows: credit stays below the toll (<= 215) while collecting.
    assign credit_sum = credit_q + cents_t'(coin_sum);
    assign go_open    = (state_q == COLLECT) && !car_exit && (credit_sum >= TOLL_C);
    assign go_violate = (state_q == COLLECT) && car_exit;
    assign alarm_done = (alarm_cnt_q == '0);

    // State, credit and alarm counter registers; reset closes the gate at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            credit_q    <= '0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    // Next-state logic; an exit while collecting wins over any coin that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (car_arrive) state_d = COLLECT;
            COLLECT: begin
                if (go_violate)   state_d = VIOLATE;
                else if (go_open) state_d = OPEN;
            end
            OPEN:    if (car_exit) state_d = IDLE;
            VIOLATE: if (alarm_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credit accumulation and alarm countdown for the current transaction.
    always_comb begin
        credit_d    = credit_q;
        alarm_cnt_d = alarm_cnt_q;
        case (state_q)
            COLLECT: begin
                if (go_violate) alarm_cnt_d = ALARM_LOAD;
                else            credit_d    = credit_sum;
            end
            OPEN: begin
                if (car_exit) credit_d = '0;
            end
            VIOLATE: begin
                if (alarm_done) credit_d    = '0;
                else            alarm_cnt_d = alarm_cnt_q - ALARM_W'(1);
            end
            default: ;
        endcase
    end

    // Lane outputs decoded from the registered state, so Paid is glitch-free.
    always_comb begin
        Paid   = (state_q == OPEN);
        Stop   = (state_q != OPEN);
        alarm  = (state_q == VIOLATE);
        credit = credit_q;
    end

`ifdef TOLL_CHANGE_EN
    cents_t change_q, change_d;
    logic   change_valid_q, change_valid_d;

    // Change register; the amount is held until the next paid car or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_q       <= '0;
            change_valid_q <= 1'b0;
        end else begin
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
        end
    end

    // Overpayment is computed on the cycle the gate is about to open.
    always_comb begin
        change_d       = change_q;
        change_valid_d = 1'b0;
        if (go_open) begin
            change_d       = credit_sum - TOLL_C;
            change_valid_d = 1'b1;
        end
    end

    assign change       = change_q;
    assign change_valid = change_valid_q;
`endif

endmodule

// File: tb/tb_toll_controller.sv
// tb_toll_controller: table-driven, directed and randomized checks of the
// toll_controller lane sequencer against a transaction-level reference model.
module tb_toll_controller;

    localparam int TOLL  = 35;
    localparam int ALARM = 16;

    logic       clk;
    logic       rst_n;
    logic       car_arrive, car_exit, N, D, Q;
    logic       Paid, Stop, alarm;
    logic [7:0] credit;

    logic       s_arrive, s_exit, s_n, s_d, s_q;
    logic       s_paid, s_stop, s_alarm;
    logic [7:0] s_credit;

`ifdef TOLL_CHANGE_EN
    logic [7:0] change, s_change;
    logic       change_valid, s_change_valid;
`endif

    int checks   = 0;
    int failures = 0;

    toll_controller #(.TOLL_CENTS(TOLL), .ALARM_CYCLES(ALARM)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .car_arrive (car_arrive),
        .car_exit   (car_exit),
        .N          (N),
        .D          (D),
        .Q          (Q),
        .Paid       (Paid),
        .Stop       (Stop),
        .credit     (credit),
        .alarm      (alarm)
`ifdef TOLL_CHANGE_EN
        ,
        .change       (change),
        .change_valid (change_valid)
`endif
    );

    toll_controller #(.TOLL_CENTS(5), .ALARM_CYCLES(1)) u_dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .car_arrive (s_arrive),
        .car_exit   (s_exit),
        .N          (s_n),
        .D          (s_d),
        .Q          (s_q),
        .Paid       (s_paid),
        .Stop       (s_stop),
        .credit     (s_credit),
        .alarm      (s_alarm)
`ifdef TOLL_CHANGE_EN
        ,
        .change       (s_change),
        .change_valid (s_change_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what phase of the transaction the lane is in.
    // 0 = waiting for a car, 1 = taking money, 2 = gate up, 3 = sounding alarm
    int m_phase;
    int m_credit;
    int m_alarm_left;
    int m_change;
    int m_cv;

    task automatic modelReset();
        m_phase      = 0;
        m_credit     = 0;
        m_alarm_left = 0;
        m_change     = 0;
        m_cv         = 0;
    endtask

    task automatic modelStep(input logic a, input logic e, input logic n, input logic d, input logic q);
        int paid_now;
        paid_now = 5 * int'(n) + 10 * int'(d) + 25 * int'(q);
        m_cv = 0;
        if (m_phase == 0) begin
            if (a) m_phase = 1;
        end else if (m_phase == 1) begin
            if (e) begin
                m_phase      = 3;
                m_alarm_left = ALARM;
            end else begin
                m_credit = m_credit + paid_now;
                if (m_credit >= TOLL) begin
                    m_phase  = 2;
                    m_change = m_credit - TOLL;
                    m_cv     = 1;
                end
            end
        end else if (m_phase == 2) begin
            if (e) begin
                m_phase  = 0;
                m_credit = 0;
            end
        end else begin
            m_alarm_left = m_alarm_left - 1;
            if (m_alarm_left == 0) begin
                m_phase  = 0;
                m_credit = 0;
            end
        end
    endtask

    task automatic compareVal(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int exp_paid, input int exp_credit,
                               input int exp_alarm, input int exp_change, input int exp_cv);
        compareVal(name, "Paid",   int'(Paid),   exp_paid);
        compareVal(name, "Stop",   int'(Stop),   (exp_paid != 0) ? 0 : 1);
        compareVal(name, "credit", int'(credit), exp_credit);
        compareVal(name, "alarm",  int'(alarm),  exp_alarm);
`ifdef TOLL_CHANGE_EN
        compareVal(name, "change",       int'(change),       exp_change);
        compareVal(name, "change_valid", int'(change_valid), exp_cv);
`endif
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, (m_phase == 2) ? 1 : 0, m_credit, (m_phase == 3) ? 1 : 0, m_change, m_cv);
    endtask

    task automatic applyStimulus(input logic a, input logic e, input logic n, input logic d, input logic q);
        car_arrive = a;
        car_exit   = e;
        N          = n;
        D          = d;
        Q          = q;
        @(posedge clk);
        modelStep(a, e, n, d, q);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        car_arrive = 0; car_exit = 0; N = 0; D = 0; Q = 0;
        s_arrive = 0; s_exit = 0; s_n = 0; s_d = 0; s_q = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    typedef struct {
        logic       arrive, leave, n, d, q;
        int         paid, credit, alarm, change, cv;
        string      name;
    } vec_t;

    vec_t vecs[10];

    task automatic setVec(input int idx, input logic a, input logic e, input logic n, input logic d,
                          input logic q, input int paid, input int cr, input int al, input int ch,
                          input int cv, input string name);
        vecs[idx].arrive = a; vecs[idx].leave = e;
        vecs[idx].n = n; vecs[idx].d = d; vecs[idx].q = q;
        vecs[idx].paid = paid; vecs[idx].credit = cr; vecs[idx].alarm = al;
        vecs[idx].change = ch; vecs[idx].cv = cv; vecs[idx].name = name;
    endtask

    initial begin
        int highs;

        //            a  e  n  d  q  paid cr  al ch cv
        setVec(0,     1, 0, 0, 0, 1, 0,   0,  0, 0, 0, "arrive_coin_ignored");
        setVec(1,     0, 0, 0, 0, 1, 0,  25,  0, 0, 0, "quarter");
        setVec(2,     0, 0, 0, 1, 0, 1,  35,  0, 0, 1, "dime_pays");
        setVec(3,     1, 0, 1, 0, 0, 1,  35,  0, 0, 0, "open_ignores_coins");
        setVec(4,     0, 1, 0, 0, 0, 0,   0,  0, 0, 0, "exit_closes");
        setVec(5,     0, 0, 1, 0, 0, 0,   0,  0, 0, 0, "idle_ignores_coins");
        setVec(6,     1, 0, 0, 0, 0, 0,   0,  0, 0, 0, "arrive2");
        setVec(7,     0, 0, 1, 1, 1, 1,  40,  0, 5, 1, "all_coins_one_cycle");
        setVec(8,     0, 0, 0, 0, 0, 1,  40,  0, 5, 0, "change_held");
        setVec(9,     0, 1, 0, 0, 0, 0,   0,  0, 5, 0, "exit2");

        doReset();
        checkOutput("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].arrive, vecs[i].leave, vecs[i].n, vecs[i].d, vecs[i].q);
            checkOutput(vecs[i].name, vecs[i].paid, vecs[i].credit, vecs[i].alarm,
                        vecs[i].change, vecs[i].cv);
        end

        // Unpaid exit with a simultaneous coin, then a timed alarm.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        compareVal("violate_pre", "credit", int'(credit), 10);
        applyStimulus(0, 1, 0, 0, 1);
        checkModel("violate_enter");
        compareVal("violate_enter", "credit_no_quarter", int'(credit), 10);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            if (!alarm) break;
            highs++;
            applyStimulus(1, 0, 0, 0, 0);
            checkModel("violate_hold");
        end
        compareVal("violate", "alarm_cycles", highs, ALARM);
        compareVal("violate_exit", "credit", int'(credit), 0);
        compareVal("violate_exit", "Paid", int'(Paid), 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkModel("after_violate_collect");

        // Asynchronous reset while the gate is open.
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("open_before_reset", 1, 35, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0, 0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("after_reset_idle", 0, 0, 0, 0, 0);

        // Minimum toll lane: one nickel pays, one-cycle alarm.
        s_arrive = 1;
        applyStimulus(0, 0, 0, 0, 0);
        s_arrive = 0; s_n = 1;
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("small_nickel", "Paid", int'(s_paid), 1);
        compareVal("small_nickel", "Stop", int'(s_stop), 0);
        compareVal("small_nickel", "credit", int'(s_credit), 5);
`ifdef TOLL_CHANGE_EN
        compareVal("small_nickel", "change", int'(s_change), 0);
        compareVal("small_nickel", "change_valid", int'(s_change_valid), 1);
`endif
        s_n = 0; s_exit = 1;
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("small_exit", "Paid", int'(s_paid), 0);
        compareVal("small_exit", "credit", int'(s_credit), 0);
        s_exit = 0; s_arrive = 1;
        applyStimulus(0, 0, 0, 0, 0);
        s_arrive = 0; s_exit = 1;
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("small_violate", "alarm", int'(s_alarm), 1);
        compareVal("small_violate", "Stop", int'(s_stop), 1);
        s_exit = 0;
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("small_violate_end", "alarm", int'(s_alarm), 0);

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(logic'($urandom_range(0, 2) == 0),
                          logic'($urandom_range(0, 9) == 0),
                          logic'($urandom_range(0, 3) == 0),
                          logic'($urandom_range(0, 3) == 0),
                          logic'($urandom_range(0, 3) == 0));
            checkModel("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
